amo_sequencer: RTL and testbench
================================

Name: amo_sequencer

Overview:
- Memory-stage sequencer for RV32A instructions (LR.W, SC.W, AMO*.W).
- Accepts one atomic request from the pipeline and performs the memory transactions: read, read-modify-write, or conditional write.
- Drives the reservation monitor's update/address/type strobes and consumes its SC success result.
- Returns the architectural rd value to writeback.

Parameters:
- XLEN, 32, data and address width.
- ADDR_ALIGN_CHECK, 1, when 1 a misaligned address (addr[1:0] != 0) raises resp_err and performs no memory access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  atomic request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_funct5  in  5  RV32A funct5 (aq/rl bits ignored)
- req_addr  in  XLEN  effective address (rs1)
- req_rs2  in  XLEN  rs2 operand
- mem_addr  out  XLEN  memory address
- mem_rd  out  1  read request, held until mem_done
- mem_wr  out  1  write request, held until mem_done
- mem_wdata  out  XLEN  write data
- mem_rdata  in  XLEN  read data, valid when mem_done && mem_rd
- mem_done  in  1  current memory phase complete
- mon_update  out  1  one-cycle strobe to the reservation monitor
- mon_addr  out  XLEN  address presented to the monitor (= latched addr)
- mon_is_lr  out  1  current op is LR
- mon_is_sc  out  1  current op is SC
- mon_wr  out  1  current op writes memory (AMO, or successful SC)
- mon_success  in  1  combinational SC success from the monitor
- resp_valid  out  1  one-cycle result strobe
- resp_data  out  XLEN  rd value
- resp_err  out  1  misaligned or illegal funct5

Behaviour:
- Reset: state=IDLE; req_ready=1; all other outputs 0; latched registers cleared.
  - rst in any state aborts immediately; mem_rd/mem_wr drop the next cycle.
  - No resp_valid is produced for an aborted request.
- funct5 encodings:
  - LR 00010, SC 00011, SWAP 00001, ADD 00000, XOR 00100.
  - AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
  - Any other value is illegal.
- States: IDLE, READ, WRITE, SC_CHK, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch funct5, addr and rs2.
  - Illegal funct5, or misaligned address with ADDR_ALIGN_CHECK=1: go to RESP with resp_err=1 and resp_data=0. No memory access and no monitor strobe.
  - LR or AMO: go to READ. SC: go to SC_CHK.
- READ:
  - mem_rd=1 and mem_addr=addr until mem_done; capture mem_rdata into old.
  - LR: on mem_done, pulse mon_update with mon_is_lr=1, then go to RESP.
  - AMO: on mem_done, go to WRITE.
- WRITE:
  - mem_wr=1 until mem_done.
  - AMO write data is f(old, rs2): SWAP=rs2; ADD = wrap-around 32-bit sum; AND/OR/XOR bitwise.
  - MIN/MAX use signed compare; MINU/MAXU use unsigned compare. Ties select old.
  - SC write data is rs2.
  - On mem_done, pulse mon_update with mon_wr=1, then go to RESP.
- SC_CHK (one cycle):
  - Drive mon_is_sc=1 and mon_addr=addr; sample mon_success.
  - Success: record result 0 and go to WRITE.
  - Failure: pulse mon_update this cycle with mon_wr=0, record result 1, and go to RESP. No memory write.
- Monitor strobe:
  - In the successful-SC WRITE, mon_is_sc stays 1 through the mon_update pulse.
  - Exactly one mon_update per legal request, never more.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_data is old (LR/AMO) or the SC result (0/1).
  - No response backpressure; req_ready is low from the accept cycle through RESP.
- Latency with single-cycle memory (mem_done in the first request cycle), accept at cycle 0:
  - LR: resp_valid at cycle 2.
  - AMO: cycle 3.
  - SC success: cycle 3.
  - SC failure: cycle 2.
- mem_done outside READ/WRITE is ignored. mem_rd and mem_wr are never both high.
- Multi-cycle memory stretches READ/WRITE only; mem_addr, mem_wdata and the mon_* lines stay stable throughout.

Test Plan:
- AMOADD, mem[0x100]=0x7FFFFFFF, rs2=1, 1-cycle memory -> write 0x80000000; resp_data=0x7FFFFFFF at cycle 3; one mon_update with mon_wr=1.
- AMOMIN vs AMOMINU, old=0xFFFFFFFF, rs2=0x1 -> MIN writes 0xFFFFFFFF; MINU writes 0x00000001; both return 0xFFFFFFFF.
- LR 0x200 then SC 0x200 with mon_success=1 -> LR returns memory data; SC writes rs2 and resp_data=0; each op produces exactly one mon_update.
- SC with mon_success=0 -> no mem_wr; resp_data=1 at cycle 2; one mon_update with mon_wr=0.
- AMOSWAP with mem_done delayed 4 cycles in each phase -> mem_rd/mem_wr held stable; resp_valid at cycle 9.
  - Repeat with rst asserted mid-WRITE -> all outputs 0 next cycle, no resp_valid, req_ready=1.
- req_addr=0x102 or funct5=11111 -> resp_err=1 at cycle 1; no mem_rd, mem_wr or mon_update.

Source files
------------

// File: rtl/amo_sequencer.sv
// amo_sequencer
//   Memory-stage sequencer for RV32A atomics (LR.W, SC.W, AMO*.W). Accepts
//   one request at a time, runs the read / read-modify-write / conditional
//   write phases against a simple handshake memory port, strobes the
//   reservation monitor once per legal request and returns the rd value.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_funct5, req_addr,
//   req_rs2                  RV32A funct5 (aq/rl not used), rs1 address, rs2
//   mem_addr, mem_rd, mem_wr,
//   mem_wdata, mem_rdata,
//   mem_done                 memory phase interface; rd/wr held until done
//   mon_update, mon_addr,
//   mon_is_lr, mon_is_sc,
//   mon_wr, mon_success      reservation monitor interface
//   resp_valid, resp_data,
//   resp_err                 one-cycle writeback result
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// READ   | mem_rd held until mem_done, old value captured
// WRITE  | mem_wr held until mem_done (AMO result or SC rs2)
// SC_CHK | one cycle: sample reservation monitor success
// RESP   | resp_valid for one cycle

module amo_sequencer #(
  parameter int XLEN             = 32,
  parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_funct5,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_rs2,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_done,
  output logic            mon_update,
  output logic [XLEN-1:0] mon_addr,
  output logic            mon_is_lr,
  output logic            mon_is_sc,
  output logic            mon_wr,
  input  logic            mon_success,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err
);

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    SC_CHK = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [4:0]      r_funct5;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_wdata;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic            r_mon_is_lr;
  logic            r_mon_is_sc;
  logic            r_mon_wr;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_data;
  logic            r_resp_err;

  logic            w_legal;
  logic            w_misaligned;
  logic            w_req_is_lr;
  logic            w_req_is_sc;
  logic            w_mon_update;
  logic [XLEN-1:0] w_amo_result;

  function automatic logic legal_funct5(input logic [4:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
      F_MIN, F_MAX, F_MINU, F_MAXU: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Ties select old for all four min/max flavours.
  function automatic logic [XLEN-1:0] amo_op(input logic [4:0]      f,
                                             input logic [XLEN-1:0] old,
                                             input logic [XLEN-1:0] rs2);
    logic [XLEN-1:0] res;
    res = old;
    case (f)
      F_SWAP:  res = rs2;
      F_ADD:   res = old + rs2;
      F_XOR:   res = old ^ rs2;
      F_AND:   res = old & rs2;
      F_OR:    res = old | rs2;
      F_MIN:   res = ($signed(old) <= $signed(rs2)) ? old : rs2;
      F_MAX:   res = ($signed(old) >= $signed(rs2)) ? old : rs2;
      F_MINU:  res = (old <= rs2) ? old : rs2;
      F_MAXU:  res = (old >= rs2) ? old : rs2;
      default: res = old;
    endcase
    return res;
  endfunction

  assign w_legal      = legal_funct5(req_funct5);
  assign w_misaligned = ADDR_ALIGN_CHECK && (req_addr[1:0] != 2'b00);
  assign w_req_is_lr  = (req_funct5 == F_LR);
  assign w_req_is_sc  = (req_funct5 == F_SC);
  assign w_amo_result = amo_op(r_funct5, mem_rdata, r_rs2);

  // The monitor's success flag is combinational on mon_is_sc/mon_addr, so a
  // failed SC must strobe in the same SC_CHK cycle; the READ/WRITE strobes
  // follow the same same-cycle-as-completion timing for consistency.
  assign w_mon_update = ((r_state == READ)   && mem_done && r_mon_is_lr) ||
                        ((r_state == WRITE)  && mem_done)                ||
                        ((r_state == SC_CHK) && !mon_success);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_funct5     <= '0;
      r_addr       <= '0;
      r_rs2        <= '0;
      r_result     <= '0;
      r_wdata      <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mon_is_lr  <= 1'b0;
      r_mon_is_sc  <= 1'b0;
      r_mon_wr     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_funct5 <= req_funct5;
            r_addr   <= req_addr;
            r_rs2    <= req_rs2;
            r_result <= '0;
            if (!w_legal || w_misaligned) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= '0;
            end else if (w_req_is_sc) begin
              r_state     <= SC_CHK;
              r_mon_is_sc <= 1'b1;
            end else begin
              r_state     <= READ;
              r_mem_rd    <= 1'b1;
              r_mon_is_lr <= w_req_is_lr;
              r_mon_wr    <= !w_req_is_lr;
            end
          end
        end

        READ: begin
          if (mem_done) begin
            r_mem_rd <= 1'b0;
            r_result <= mem_rdata;
            if (r_mon_is_lr) begin
              r_state      <= RESP;
              r_mon_is_lr  <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_data  <= mem_rdata;
            end else begin
              r_state  <= WRITE;
              r_mem_wr <= 1'b1;
              r_wdata  <= w_amo_result;
            end
          end
        end

        SC_CHK: begin
          if (mon_success) begin
            r_state  <= WRITE;
            r_mem_wr <= 1'b1;
            r_wdata  <= r_rs2;
            r_mon_wr <= 1'b1;
            r_result <= '0;
          end else begin
            r_state      <= RESP;
            r_mon_is_sc  <= 1'b0;
            r_result     <= {{(XLEN-1){1'b0}}, 1'b1};
            r_resp_valid <= 1'b1;
            r_resp_data  <= {{(XLEN-1){1'b0}}, 1'b1};
          end
        end

        WRITE: begin
          if (mem_done) begin
            r_state      <= RESP;
            r_mem_wr     <= 1'b0;
            r_wdata      <= '0;
            r_mon_is_sc  <= 1'b0;
            r_mon_wr     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= r_result;
          end
        end

        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_data  <= '0;
          r_resp_err   <= 1'b0;
        end

        default: begin
          r_state      <= IDLE;
          r_mem_rd     <= 1'b0;
          r_mem_wr     <= 1'b0;
          r_mon_is_lr  <= 1'b0;
          r_mon_is_sc  <= 1'b0;
          r_mon_wr     <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign mem_addr   = r_addr;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_wdata  = r_wdata;
  assign mon_update = w_mon_update;
  assign mon_addr   = r_addr;
  assign mon_is_lr  = r_mon_is_lr;
  assign mon_is_sc  = r_mon_is_sc;
  assign mon_wr     = r_mon_wr;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_amo_sequencer.sv
// tb_amo_sequencer
//   Directed bench for amo_sequencer: a word memory with programmable
//   done latency, a constant reservation-monitor success input, and
//   hand-computed expectations per request.

module tb_amo_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_funct5;
  logic [31:0] req_addr;
  logic [31:0] req_rs2;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mon_update;
  logic [31:0] mon_addr;
  logic        mon_is_lr;
  logic        mon_is_sc;
  logic        mon_wr;
  logic        mon_success;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  amo_sequencer #(.XLEN(32), .ADDR_ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
    .req_addr(req_addr), .req_rs2(req_rs2),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mon_update(mon_update), .mon_addr(mon_addr), .mon_is_lr(mon_is_lr),
    .mon_is_sc(mon_is_sc), .mon_wr(mon_wr), .mon_success(mon_success),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  // memory model
  int          mem_lat;
  int          wcnt;
  logic [31:0] mem_a [0:1023];
  logic        pre_we;
  logic [31:0] pre_addr;
  logic [31:0] pre_data;

  assign mem_done  = (mem_rd || mem_wr) && (wcnt == mem_lat - 1);
  assign mem_rdata = mem_rd ? mem_a[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (rst || !(mem_rd || mem_wr) || mem_done) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem_wr && mem_done) mem_a[mem_addr[11:2]] <= mem_wdata;
    if (pre_we) mem_a[pre_addr[11:2]] <= pre_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled away from the active edge
  int n_upd = 0, n_upd_wr = 0, n_upd_lr = 0, n_upd_sc = 0;
  int n_rd = 0, n_wr = 0, n_resp = 0, n_both = 0, n_stab = 0;
  logic        in_phase = 1'b0;
  logic [1:0]  ph_rw = 2'b00;
  logic [98:0] ph_snap = '0;

  always @(negedge clk) begin
    if (mon_update) begin
      n_upd = n_upd + 1;
      if (mon_wr)    n_upd_wr = n_upd_wr + 1;
      if (mon_is_lr) n_upd_lr = n_upd_lr + 1;
      if (mon_is_sc) n_upd_sc = n_upd_sc + 1;
    end
    if (mem_rd) n_rd = n_rd + 1;
    if (mem_wr) n_wr = n_wr + 1;
    if (mem_rd && mem_wr) n_both = n_both + 1;
    if (resp_valid) n_resp = n_resp + 1;
    if (mem_rd || mem_wr) begin
      if (!in_phase || ph_rw != {mem_rd, mem_wr}) begin
        ph_snap = {mem_addr, mem_wdata, mon_addr, mon_is_lr, mon_is_sc, mon_wr};
        ph_rw   = {mem_rd, mem_wr};
      end else if (ph_snap != {mem_addr, mem_wdata, mon_addr, mon_is_lr, mon_is_sc, mon_wr}) begin
        n_stab = n_stab + 1;
      end
    end
    in_phase = mem_rd || mem_wr;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem_a[a[11:2]];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // per-request results
  int          o_lat;
  logic [31:0] o_data;
  logic        o_err;
  int d_upd, d_upd_wr, d_upd_lr, d_upd_sc, d_rd, d_wr, d_resp, d_both, d_stab;

  task automatic run_req(input logic [4:0] f, input logic [31:0] a, input logic [31:0] d);
    int acc;
    int b_upd, b_upd_wr, b_upd_lr, b_upd_sc, b_rd, b_wr, b_resp, b_both, b_stab;
    @(negedge clk);
    req_valid = 1'b1; req_funct5 = f; req_addr = a; req_rs2 = d;
    b_upd = n_upd; b_upd_wr = n_upd_wr; b_upd_lr = n_upd_lr; b_upd_sc = n_upd_sc;
    b_rd = n_rd; b_wr = n_wr; b_resp = n_resp; b_both = n_both; b_stab = n_stab;
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    o_lat = -1; o_data = 32'hDEAD_DEAD; o_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        o_lat  = cyc - acc;
        o_data = resp_data;
        o_err  = resp_err;
        break;
      end
    end
    repeat (2) @(negedge clk);
    d_upd = n_upd - b_upd; d_upd_wr = n_upd_wr - b_upd_wr;
    d_upd_lr = n_upd_lr - b_upd_lr; d_upd_sc = n_upd_sc - b_upd_sc;
    d_rd = n_rd - b_rd; d_wr = n_wr - b_wr; d_resp = n_resp - b_resp;
    d_both = n_both - b_both; d_stab = n_stab - b_stab;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   b_resp;
    rst = 1'b1; req_valid = 1'b0; req_funct5 = 5'b0; req_addr = '0; req_rs2 = '0;
    mon_success = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; mem_lat = 1;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rdwr", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_mon", {28'd0, mon_update, mon_is_lr, mon_is_sc, mon_wr}, 32'd0);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // AMOADD wrap
    preload(32'h100, 32'h7FFF_FFFF);
    run_req(5'b00000, 32'h100, 32'h1);
    chk("add_lat", o_lat, 32'd3);
    chk("add_data", o_data, 32'h7FFF_FFFF);
    chk("add_err", 32'(o_err), 32'd0);
    chk("add_mem", mem_at(32'h100), 32'h8000_0000);
    chk("add_upd", d_upd, 32'd1);
    chk("add_upd_wr", d_upd_wr, 32'd1);
    chk("add_resp_cnt", d_resp, 32'd1);
    chk("add_ready", 32'(req_ready), 32'd1);

    // signed vs unsigned min
    preload(32'h104, 32'hFFFF_FFFF);
    run_req(5'b10000, 32'h104, 32'h1);
    chk("min_data", o_data, 32'hFFFF_FFFF);
    chk("min_mem", mem_at(32'h104), 32'hFFFF_FFFF);
    preload(32'h104, 32'hFFFF_FFFF);
    run_req(5'b11000, 32'h104, 32'h1);
    chk("minu_data", o_data, 32'hFFFF_FFFF);
    chk("minu_mem", mem_at(32'h104), 32'h0000_0001);

    preload(32'h108, 32'h8000_0000);
    run_req(5'b10100, 32'h108, 32'h1);
    chk("max_data", o_data, 32'h8000_0000);
    chk("max_mem", mem_at(32'h108), 32'h0000_0001);

    preload(32'h110, 32'hF0F0_F0F0);
    run_req(5'b01100, 32'h110, 32'hFF00_FF00);
    chk("and_mem", mem_at(32'h110), 32'hF000_F000);

    // LR then successful SC
    preload(32'h200, 32'hCAFE_BABE);
    run_req(5'b00010, 32'h200, 32'h0);
    chk("lr_lat", o_lat, 32'd2);
    chk("lr_data", o_data, 32'hCAFE_BABE);
    chk("lr_upd", d_upd, 32'd1);
    chk("lr_upd_lr", d_upd_lr, 32'd1);
    chk("lr_wr", d_wr, 32'd0);

    mon_success = 1'b1;
    run_req(5'b00011, 32'h200, 32'h1234_5678);
    chk("sc_lat", o_lat, 32'd3);
    chk("sc_data", o_data, 32'd0);
    chk("sc_mem", mem_at(32'h200), 32'h1234_5678);
    chk("sc_upd", d_upd, 32'd1);
    chk("sc_upd_sc", d_upd_sc, 32'd1);
    chk("sc_upd_wr", d_upd_wr, 32'd1);

    // failed SC
    mon_success = 1'b0;
    preload(32'h300, 32'hAAAA_5555);
    run_req(5'b00011, 32'h300, 32'h1);
    chk("scf_lat", o_lat, 32'd2);
    chk("scf_data", o_data, 32'd1);
    chk("scf_wr", d_wr, 32'd0);
    chk("scf_upd", d_upd, 32'd1);
    chk("scf_upd_wr", d_upd_wr, 32'd0);
    chk("scf_mem", mem_at(32'h300), 32'hAAAA_5555);

    // slow memory SWAP
    mem_lat = 4;
    preload(32'h400, 32'h1111_1111);
    run_req(5'b00001, 32'h400, 32'h2222_2222);
    chk("swap_lat", o_lat, 32'd9);
    chk("swap_data", o_data, 32'h1111_1111);
    chk("swap_mem", mem_at(32'h400), 32'h2222_2222);
    chk("swap_rd_cyc", d_rd, 32'd4);
    chk("swap_wr_cyc", d_wr, 32'd4);
    chk("swap_stable", d_stab, 32'd0);
    chk("swap_both", d_both, 32'd0);
    chk("swap_upd", d_upd, 32'd1);

    // reset in the middle of WRITE
    preload(32'h500, 32'h3333_3333);
    @(negedge clk);
    req_valid = 1'b1; req_funct5 = 5'b00001; req_addr = 32'h500; req_rs2 = 32'h4444_4444;
    b_resp = n_resp;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_wr) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_wr_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rdwr", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("abort_mon", {28'd0, mon_update, mon_is_lr, mon_is_sc, mon_wr}, 32'd0);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_resp", n_resp - b_resp, 32'd0);
    chk("abort_mem", mem_at(32'h500), 32'h3333_3333);

    // error paths
    mem_lat = 1;
    run_req(5'b00000, 32'h102, 32'h5);
    chk("mis_lat", o_lat, 32'd1);
    chk("mis_err", 32'(o_err), 32'd1);
    chk("mis_data", o_data, 32'd0);
    chk("mis_mem_acc", d_rd + d_wr, 32'd0);
    chk("mis_upd", d_upd, 32'd0);

    run_req(5'b11111, 32'h100, 32'h5);
    chk("ill_lat", o_lat, 32'd1);
    chk("ill_err", 32'(o_err), 32'd1);
    chk("ill_mem_acc", d_rd + d_wr, 32'd0);
    chk("ill_upd", d_upd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
